// File: rtl/move_ctrl_pkg.sv
// Shared definitions for the register-transfer control FSM: state encodings,
// default opcodes, decode result type and immediate extension helper.
package move_ctrl_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE  = 4'd0;
    localparam logic [ST_W-1:0] ST_RD_J  = 4'd1;
    localparam logic [ST_W-1:0] ST_CAP_J = 4'd2;
    localparam logic [ST_W-1:0] ST_RD_I  = 4'd3;
    localparam logic [ST_W-1:0] ST_CAP_I = 4'd4;
    localparam logic [ST_W-1:0] ST_WR_I  = 4'd5;
    localparam logic [ST_W-1:0] ST_WR_J  = 4'd6;
    localparam logic [ST_W-1:0] ST_ERR   = 4'd7;
    localparam logic [ST_W-1:0] ST_DONE  = 4'd8;

    localparam int DEF_OPC_MOVI = 9;
    localparam int DEF_OPC_MOV  = 10;
    localparam int DEF_OPC_XCHG = 11;

    // Widest immediate/data the extension helper handles.
    localparam int EXT_MAX_W = 64;

    typedef struct packed {
        logic isMovi;
        logic isMov;
        logic isXchg;
        logic illegal;
    } decode_t;

    function automatic logic [EXT_MAX_W-1:0] extendImm(
        input logic [EXT_MAX_W-1:0] immIn,
        input int                   immW,
        input logic                 signExt
    );
        logic [EXT_MAX_W-1:0] res;
        res = '0;
        for (int b = 0; b < EXT_MAX_W; b++) begin
            if (b < immW) begin
                res[b] = immIn[b];
            end else begin
                res[b] = signExt & immIn[immW-1];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/move_op_decode.sv
// Combinational instruction classifier: opcode class plus register-index
// range check against the configured register count.
module move_op_decode
    import move_ctrl_pkg::*;
#(
    parameter int              NREG     = 4,
    parameter int              AW       = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int              OP_W     = 4,
    parameter logic [OP_W-1:0] OPC_MOVI = OP_W'(DEF_OPC_MOVI),
    parameter logic [OP_W-1:0] OPC_MOV  = OP_W'(DEF_OPC_MOV),
    parameter logic [OP_W-1:0] OPC_XCHG = OP_W'(DEF_OPC_XCHG)
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [AW-1:0]   ri,
    input  logic [AW-1:0]   rj,
    output decode_t         dec
);

    // One extra bit so NREG == 2**AW is representable.
    localparam logic [AW:0] NREG_V = (AW + 1)'(NREG);

    logic idxOk;

    always_comb begin
        dec        = '0;
        dec.isMovi = (opcode == OPC_MOVI);
        dec.isMov  = (opcode == OPC_MOV);
        dec.isXchg = (opcode == OPC_XCHG);
        idxOk      = ({1'b0, ri} < NREG_V) && ({1'b0, rj} < NREG_V);
        dec.illegal = !(dec.isMovi || dec.isMov || dec.isXchg) || !idxOk;
    end

endmodule

// File: rtl/move_ctrl_fsm.sv
// Register-transfer control FSM executing MOV, MOVI and XCHG against a
// synchronous register file, with a busy/done/illegal sequencer handshake.
module move_ctrl_fsm
    import move_ctrl_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter int              NREG     = 4,
    parameter int              AW       = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int              IMM_W    = 8,
    parameter int              IMM_SEXT = 0,
    parameter int              OP_W     = 4,
    parameter logic [OP_W-1:0] OPC_MOVI = OP_W'(DEF_OPC_MOVI),
    parameter logic [OP_W-1:0] OPC_MOV  = OP_W'(DEF_OPC_MOV),
    parameter logic [OP_W-1:0] OPC_XCHG = OP_W'(DEF_OPC_XCHG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [AW-1:0]     ri,
    input  logic [AW-1:0]     rj,
    input  logic [IMM_W-1:0]  imm,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   nextState;
    logic [OP_W-1:0]   opQ;
    logic [AW-1:0]     riQ;
    logic [AW-1:0]     rjQ;
    logic [IMM_W-1:0]  immQ;
    logic [DATA_W-1:0] tmpJ;
    logic [DATA_W-1:0] tmpI;
    logic [DATA_W-1:0] immExt;
    decode_t           dec;

    move_op_decode #(
        .NREG     (NREG),
        .AW       (AW),
        .OP_W     (OP_W),
        .OPC_MOVI (OPC_MOVI),
        .OPC_MOV  (OPC_MOV),
        .OPC_XCHG (OPC_XCHG)
    ) uDecode (
        .opcode (opcode),
        .ri     (ri),
        .rj     (rj),
        .dec    (dec)
    );

    assign immExt = DATA_W'(extendImm({{(EXT_MAX_W - IMM_W){1'b0}}, immQ},
                                      IMM_W, IMM_SEXT != 0));

    always_comb begin
        nextState = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (!start) begin
                    nextState = ST_IDLE;
                end else if (dec.illegal) begin
                    nextState = ST_ERR;
                end else if (dec.isMovi) begin
                    nextState = ST_WR_I;
                end else if (dec.isMov || dec.isXchg) begin
                    nextState = ST_RD_J;
                end else begin
                    nextState = ST_ERR;
                end
            end
            ST_RD_J:  nextState = ST_CAP_J;
            ST_CAP_J: nextState = (opQ == OPC_XCHG) ? ST_RD_I : ST_WR_I;
            ST_RD_I:  nextState = ST_CAP_I;
            ST_CAP_I: nextState = ST_WR_I;
            ST_WR_I:  nextState = (opQ == OPC_XCHG) ? ST_WR_J : ST_DONE;
            ST_WR_J:  nextState = ST_DONE;
            ST_ERR:   nextState = ST_IDLE;
            ST_DONE:  nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Operands are captured only on an accepted instruction, so start pulses
    // while busy cannot disturb an operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opQ  <= '0;
            riQ  <= '0;
            rjQ  <= '0;
            immQ <= '0;
        end else if (state == ST_IDLE && start) begin
            opQ  <= opcode;
            riQ  <= ri;
            rjQ  <= rj;
            immQ <= imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmpJ <= '0;
            tmpI <= '0;
        end else begin
            if (state == ST_CAP_J) begin
                tmpJ <= rd_data;
            end
            if (state == ST_CAP_I) begin
                tmpI <= rd_data;
            end
        end
    end

    // Moore outputs: decoded from state and latched operands only.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            ST_RD_J: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = rjQ;
            end
            ST_CAP_J: busy = 1'b1;
            ST_RD_I: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = riQ;
            end
            ST_CAP_I: busy = 1'b1;
            ST_WR_I: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = riQ;
                wr_data = (opQ == OPC_MOVI) ? immExt : tmpJ;
            end
            ST_WR_J: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = rjQ;
                wr_data = tmpI;
            end
            ST_ERR: begin
                busy    = 1'b1;
                done    = 1'b1;
                illegal = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_move_ctrl_fsm.sv
// Scoreboard bench for move_ctrl_fsm: randomized instructions against a
// timetable reference model and a behavioural register file.
module tb_move_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] opcode;
    logic [1:0] ri;
    logic [1:0] rj;
    logic [3:0] imm;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] rdData;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    move_ctrl_fsm #(
        .DATA_W   (8),
        .NREG     (3),
        .IMM_W    (4),
        .IMM_SEXT (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .opcode  (opcode),
        .ri      (ri),
        .rj      (rj),
        .imm     (imm),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rdData),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous register file driven by the DUT.
    logic [7:0] rf [4] = '{8'h3C, 8'h11, 8'h22, 8'h5A};
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_data;
        if (rd_en) rdData <= rf[rd_addr];
    end

    // kind: 0 read, 1 write, 2 done (data = expected illegal flag)
    typedef struct {
        int kind;
        int addr;
        int data;
        int cyc;
    } ev_t;

    ev_t        q[$];
    logic [7:0] refRegs [4];
    int         nChecks = 0;
    int         nPass = 0;
    int         busyFrom = 1;
    int         busyTo = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic failNow(input string msg);
        nChecks++;
        $display("FAIL %s", msg);
    endtask

    task automatic push(input int kind, input int addr, input int data, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        q.push_back(e);
    endtask

    function automatic int extImm(input int v);
        return (v >= 8) ? v + 240 : v;
    endfunction

    task automatic expectEv(input int kind, input int addr, input int data);
        ev_t e;
        if (q.size() == 0) begin
            failNow($sformatf("unexpected_event: got kind %0d addr %0d data %0h at cycle %0d, expected none",
                              kind, addr, data, cyc));
        end else begin
            e = q.pop_front();
            check($sformatf("event_kind@%0d", cyc), kind, e.kind);
            check($sformatf("event_addr_k%0d", kind), addr, e.addr);
            if (kind != 0) check($sformatf("event_data_k%0d", kind), data, e.data);
            check($sformatf("event_cycle_k%0d", kind), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                ev_t m;
                m = q.pop_front();
                failNow($sformatf("missing_event: got none, expected kind %0d addr %0d data %0h at cycle %0d",
                                  m.kind, m.addr, m.data, m.cyc));
            end
            check("busy", int'(busy), int'(cyc >= busyFrom && cyc <= busyTo));
            check("rd_wr_exclusive", int'(rd_en & wr_en), 0);
            if (rd_en) expectEv(0, int'(rd_addr), 0);
            if (wr_en) expectEv(1, int'(wr_addr), int'(wr_data));
            if (done) expectEv(2, 0, int'(illegal));
            else check("illegal_without_done", int'(illegal), 0);
        end
    end

    // Called at a negedge while the DUT is idle; returns at the negedge of
    // the first idle cycle after completion (plus gap cycles).
    task automatic issue(input int op, input int i, input int j, input int im,
                         input int gap, input bit hold);
        int         s;
        int         lat;
        logic [7:0] vi;
        logic [7:0] vj;
        bit         legal;
        start  = 1'b1;
        opcode = 4'(op);
        ri     = 2'(i);
        rj     = 2'(j);
        imm    = 4'(im);
        s      = cyc + 1;
        legal  = (op >= 9 && op <= 11) && i < 3 && j < 3;
        if (!legal) begin
            push(2, 0, 1, s);
            lat = 1;
        end else if (op == 9) begin
            push(1, i, extImm(im), s);
            push(2, 0, 0, s + 1);
            refRegs[i] = 8'(extImm(im));
            lat = 2;
        end else if (op == 10) begin
            vj = refRegs[j];
            push(0, j, 0, s);
            push(1, i, int'(vj), s + 2);
            push(2, 0, 0, s + 3);
            refRegs[i] = vj;
            lat = 4;
        end else begin
            vi = refRegs[i];
            vj = refRegs[j];
            push(0, j, 0, s);
            push(0, i, 0, s + 2);
            push(1, i, int'(vj), s + 4);
            push(1, j, int'(vi), s + 5);
            push(2, 0, 0, s + 6);
            refRegs[i] = vj;
            refRegs[j] = vi;
            lat = 7;
        end
        busyFrom = s;
        busyTo   = s + lat - 1;
        repeat (lat) begin
            @(negedge clk);
            start  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            opcode = 4'($urandom);
            ri     = 2'($urandom);
            rj     = 2'($urandom);
            imm    = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int         op;
        int         r;
        int         s;
        logic [7:0] vi;
        logic [7:0] vj;
        for (int k = 0; k < 4; k++) refRegs[k] = rf[k];
        reset  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        ri     = '0;
        rj     = '0;
        imm    = '0;
        #2;
        check("reset_outputs", int'({busy, done, illegal, rd_en, rd_addr, wr_en, wr_addr, wr_data}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        issue(9, 2, 0, 4'h9, 0, 0);
        issue(9, 1, 0, 4'h5, 1, 0);
        issue(10, 1, 2, 0, 0, 0);
        issue(11, 0, 2, 0, 0, 0);
        issue(11, 1, 1, 0, 2, 0);
        issue(10, 0, 0, 0, 0, 0);
        issue(3, 0, 1, 0, 0, 0);
        issue(9, 3, 0, 1, 0, 0);
        issue(10, 0, 3, 0, 1, 0);
        issue(10, 1, 2, 0, 0, 1);
        issue(10, 2, 0, 0, 0, 1);

        for (int n = 0; n < 80; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 9 : (r < 6) ? 10 : (r < 9) ? 11 : $urandom_range(0, 15);
            issue(op,
                  ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2),
                  $urandom_range(0, 15),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  $urandom_range(0, 3) == 0);
        end

        // XCHG R0,R2 aborted by reset while in its second write cycle.
        vi     = refRegs[0];
        vj     = refRegs[2];
        start  = 1'b1;
        opcode = 4'd11;
        ri     = 2'd0;
        rj     = 2'd2;
        s      = cyc + 1;
        push(0, 2, 0, s);
        push(0, 0, 0, s + 2);
        push(1, 0, int'(vj), s + 4);
        refRegs[0] = vj;
        busyFrom   = s;
        busyTo     = s + 4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("wr_j_before_reset", int'({wr_en, wr_addr, wr_data}), int'({1'b1, 2'd2, vi}));
        #1 reset = 1'b1;
        #1;
        check("outputs_after_async_reset",
              int'({busy, done, illegal, rd_en, rd_addr, wr_en, wr_addr, wr_data}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        issue(10, 1, 0, 0, 0, 0);
        issue(11, 2, 1, 0, 0, 0);
        repeat (3) @(negedge clk);

        check("scoreboard_drained", q.size(), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("regfile_r%0d", k), int'(rf[k]), int'(refRegs[k]));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
